// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port byte-enable RAM and its clear sequencer.
package ram_pkg;

    localparam int unsigned WM_NORMAL            = 0;
    localparam int unsigned WM_TRANSPARENT       = 1;
    localparam int unsigned WM_READ_BEFORE_WRITE = 2;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } seq_state_e;

    // Number of byte lanes in a word.
    function automatic int unsigned be_width(input int unsigned data_width,
                                             input int unsigned byte_size);
        return data_width / byte_size;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset zero-fill sequencer: sweeps every word address once, then holds
// init_done high until the next reset.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clear_sel_c,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  init_done
);

    localparam seq_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    seq_state_e            state;
    seq_state_e            state_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  init_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RESET_STATE;
            clear_addr <= '0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_next;
            clear_addr <= addr_next;
            init_done  <= init_next;
        end
    end

    // The sweep ends on the edge that writes the last address.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (&clear_addr) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_comb begin
        clear_sel_c = 1'b0;
        addr_next   = clear_addr;
        init_next   = 1'b0;
        if (state == ST_CLEAR) begin
            clear_sel_c = 1'b1;
            addr_next   = clear_addr + ADDR_WIDTH'(1);
        end
        if (state_next == ST_RUN) begin
            init_next = 1'b1;
        end
    end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port block RAM with byte-lane write enables, selectable
// same-address collision behaviour, optional output register and zero-fill.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_SIZE      = 8,
    parameter int unsigned WRITE_MODE     = 1,
    parameter int unsigned OUTPUT_REG     = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr_en,
    input  logic [ADDR_WIDTH-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]                      wr_data,
    input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0] wr_byte_en,
    input  logic                                       rd_en,
    input  logic [ADDR_WIDTH-1:0]                      rd_addr,
    output logic [DATA_WIDTH-1:0]                      rd_data,
    output logic                                       rd_valid,
    output logic                                       init_done
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);

    if ((BYTE_SIZE != 8 && BYTE_SIZE != 9) || (DATA_WIDTH % BYTE_SIZE) != 0
        || WRITE_MODE > WM_READ_BEFORE_WRITE) begin : g_bad_params
        $error("ram_sdp_be: unsupported BYTE_SIZE/DATA_WIDTH/WRITE_MODE combination");
    end

    function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [BE_WIDTH-1:0]   be);
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) merged[i*BYTE_SIZE +: BYTE_SIZE] = new_word[i*BYTE_SIZE +: BYTE_SIZE];
        end
        return merged;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clear_sel_c;
    logic [ADDR_WIDTH-1:0] clear_addr;

    ram_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_sel_c(clear_sel_c),
        .clear_addr (clear_addr),
        .init_done  (init_done)
    );

    logic                  wr_go_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [BE_WIDTH-1:0]   mem_be_c;

    // Write-port mux: the sequencer owns the port during the sweep, user requests after.
    always_comb begin
        wr_go_c     = rst && (clear_sel_c || (init_done && wr_en));
        mem_addr_c  = wr_addr;
        mem_wdata_c = wr_data;
        mem_be_c    = wr_byte_en;
        if (clear_sel_c) begin
            mem_addr_c  = clear_addr;
            mem_wdata_c = '0;
            mem_be_c    = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_go_c) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_addr_c][i*BYTE_SIZE +: BYTE_SIZE] <= mem_wdata_c[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    logic                  rd_go_c;
    logic                  collide_c;
    logic                  s1_load_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] s1_next_c;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign rd_word_c = mem[rd_addr];

    // rd_word_c is the pre-write word; collisions patch or suppress it by mode.
    always_comb begin
        rd_go_c   = rst && init_done && rd_en;
        collide_c = rd_go_c && wr_en && (rd_addr == wr_addr);
        s1_load_c = rd_go_c;
        s1_next_c = rd_word_c;
        if (collide_c) begin
            if (WRITE_MODE == WM_TRANSPARENT) begin
                s1_next_c = lane_merge(rd_word_c, wr_data, wr_byte_en);
            end else if (WRITE_MODE == WM_NORMAL) begin
                s1_load_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go_c;
            if (s1_load_c) s1_data <= s1_next_c;
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (!rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= s1_data;
            end
        end

        assign rd_data  = s2_data;
        assign rd_valid = s2_valid;
    end else begin : g_out_direct
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: directed vector table, hand sequences and randomized
// traffic checked against an array-based reference model.
module tb_ram_sdp_be;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic [31:0] tr_data, rbw_data, nrm_data, oreg_data, nc_data;
    logic        tr_valid, rbw_valid, nrm_valid, oreg_valid, nc_valid;
    logic        tr_init, rbw_init, nrm_init, oreg_init, nc_init;

    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [35:0] b_wr_data;
    logic [3:0]  b_byte_en;
    logic        b_rd_en;
    logic [3:0]  b_rd_addr;
    logic [35:0] b_data;
    logic        b_valid;
    logic        b_init;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_SIZE(8), .WRITE_MODE(1),
                 .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) u_tr (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(tr_data), .rd_valid(tr_valid), .init_done(tr_init));

    ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_SIZE(8), .WRITE_MODE(2),
                 .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) u_rbw (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rbw_data), .rd_valid(rbw_valid), .init_done(rbw_init));

    ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_SIZE(8), .WRITE_MODE(0),
                 .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) u_nrm (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(nrm_data), .rd_valid(nrm_valid), .init_done(nrm_init));

    ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_SIZE(8), .WRITE_MODE(1),
                 .OUTPUT_REG(1), .CLEAR_ON_RESET(1)) u_oreg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(oreg_data), .rd_valid(oreg_valid), .init_done(oreg_init));

    ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_SIZE(8), .WRITE_MODE(1),
                 .OUTPUT_REG(0), .CLEAR_ON_RESET(0)) u_nc (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(nc_data), .rd_valid(nc_valid), .init_done(nc_init));

    ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(36), .BYTE_SIZE(9), .WRITE_MODE(1),
                 .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) u_b9 (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_byte_en(b_byte_en), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_data), .rd_valid(b_valid), .init_done(b_init));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain word array plus the last value each output should hold.
    logic [31:0] mm [16];
    logic [31:0] m_tr, m_rbw, m_nrm, o_data;
    logic        m_v, o_v;

    function automatic logic [31:0] merge32(input logic [31:0] old_word, input logic [31:0] new_word,
                                            input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    task automatic apply(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [3:0] ra);
        logic [31:0] old_word;
        logic        coll;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be; rd_en = re; rd_addr = ra;
        old_word = mm[ra];
        coll     = re && we && (ra == wa);
        o_data   = m_tr;
        o_v      = m_v;
        if (re) begin
            m_tr  = coll ? merge32(old_word, wd, be) : old_word;
            m_rbw = old_word;
            if (!coll) m_nrm = old_word;
        end
        m_v = re;
        if (we) mm[wa] = merge32(mm[wa], wd, be);
        @(posedge clk); #1;
        check("model_tr_data",    64'(tr_data),    64'(m_tr));
        check("model_tr_valid",   64'(tr_valid),   64'(m_v));
        check("model_rbw_data",   64'(rbw_data),   64'(m_rbw));
        check("model_rbw_valid",  64'(rbw_valid),  64'(m_v));
        check("model_nrm_data",   64'(nrm_data),   64'(m_nrm));
        check("model_nrm_valid",  64'(nrm_valid),  64'(m_v));
        check("model_oreg_data",  64'(oreg_data),  64'(o_data));
        check("model_oreg_valid", 64'(oreg_valid), 64'(o_v));
        check("model_nc_valid",   64'(nc_valid),   64'(m_v));
    endtask

    task automatic idle_bus();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0; rd_en = 1'b0; rd_addr = '0;
    endtask

    // Counts edges from reset release until init_done, with requests held on the bus.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check({tag, "_noclear_init"}, 64'(nc_init), 64'(1));
            check({tag, "_valid_during_clear"}, 64'(tr_valid), 64'(0));
            check({tag, "_oreg_valid_during_clear"}, 64'(oreg_valid), 64'(0));
            if (tr_init) break;
        end
        check({tag, "_init_latency"}, 64'(n), 64'd16);
        check({tag, "_rbw_init"},  64'(rbw_init),  64'(1));
        check({tag, "_nrm_init"},  64'(nrm_init),  64'(1));
        check({tag, "_oreg_init"}, 64'(oreg_init), 64'(1));
        check({tag, "_b9_init"},   64'(b_init),    64'(1));
    endtask

    task automatic b9_step(input logic we, input logic [3:0] wa, input logic [35:0] wd,
                           input logic [3:0] be, input logic re, input logic [3:0] ra);
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_byte_en = be; b_rd_en = re; b_rd_addr = ra;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] e_tr;
        logic [31:0] e_rbw;
        logic [31:0] e_nrm;
        logic        e_v;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prev_tr;
        logic        prev_v;
        logic [3:0]  wa, ra;

        tbl[0]  = '{1'b1, 4'd5, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 4'd5, 32'h11223344, 4'h5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b1};
        tbl[3]  = '{1'b1, 4'd3, 32'h12345678, 4'hF, 1'b0, 4'd0, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
        tbl[4]  = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h3, 1'b1, 4'd3, 32'h1234FFFF, 32'h12345678, 32'hAA22CC44, 1'b1};
        tbl[5]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF, 1'b1};
        tbl[6]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd15, 32'h0, 32'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 4'd5, 32'h00000000, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b1};
        tbl[9]  = '{1'b1, 4'd9, 32'hCAFEF00D, 4'h8, 1'b1, 4'd9, 32'hCA000000, 32'h0, 32'hAA22CC44, 1'b1};
        tbl[10] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9, 32'hCA000000, 32'hCA000000, 32'hCA000000, 1'b1};

        rst = 1'b0;
        idle_bus();
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_byte_en = '0; b_rd_en = 1'b0; b_rd_addr = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data",   64'(tr_data),   64'(0));
        check("reset_rd_valid",  64'(tr_valid),  64'(0));
        check("reset_init_done", 64'(tr_init),   64'(0));
        check("reset_oreg_data", 64'(oreg_data), 64'(0));
        check("reset_nc_init",   64'(nc_init),   64'(0));

        // Plain zero-fill after release.
        rst = 1'b1;
        wait_init("clear1");

        // Reset pulse in clear cycle 7, with write/read requests held through the sweep.
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd15;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check("partial_clear_init", 64'(tr_init), 64'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midclear_reset_init",  64'(tr_init),  64'(0));
        check("midclear_reset_valid", 64'(tr_valid), 64'(0));
        rst = 1'b1;
        wait_init("clear2");
        idle_bus();

        for (int i = 0; i < 16; i++) mm[i] = '0;
        m_tr = '0; m_rbw = '0; m_nrm = '0; m_v = 1'b0; o_data = '0; o_v = 1'b0;

        // Directed vectors.
        prev_tr = '0;
        prev_v  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
            check($sformatf("vec%0d_tr_data", i),    64'(tr_data),    64'(tbl[i].e_tr));
            check($sformatf("vec%0d_rbw_data", i),   64'(rbw_data),   64'(tbl[i].e_rbw));
            check($sformatf("vec%0d_nrm_data", i),   64'(nrm_data),   64'(tbl[i].e_nrm));
            check($sformatf("vec%0d_valid", i),      64'(tr_valid),   64'(tbl[i].e_v));
            check($sformatf("vec%0d_nrm_valid", i),  64'(nrm_valid),  64'(tbl[i].e_v));
            check($sformatf("vec%0d_oreg_data", i),  64'(oreg_data),  64'(prev_tr));
            check($sformatf("vec%0d_oreg_valid", i), 64'(oreg_valid), 64'(prev_v));
            if (tbl[i].re && (tbl[i].ra == 4'd3 || tbl[i].ra == 4'd5))
                check($sformatf("vec%0d_nc_data", i), 64'(nc_data), 64'(tbl[i].e_tr));
            prev_tr = tbl[i].e_tr;
            prev_v  = tbl[i].e_v;
        end

        // Output-register latency with back-to-back reads then a gap.
        apply(1'b1, 4'd0, 32'hA, 4'hF, 1'b0, 4'd0);
        apply(1'b1, 4'd1, 32'hB, 4'hF, 1'b0, 4'd0);
        apply(1'b1, 4'd2, 32'hC, 4'hF, 1'b0, 4'd0);
        apply(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd0);
        check("oreg_c1_valid", 64'(oreg_valid), 64'(0));
        apply(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1);
        check("oreg_c2_valid", 64'(oreg_valid), 64'(1));
        check("oreg_c2_data",  64'(oreg_data),  64'h0A);
        apply(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
        check("oreg_c3_valid", 64'(oreg_valid), 64'(1));
        check("oreg_c3_data",  64'(oreg_data),  64'h0B);
        apply(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        check("oreg_c4_valid", 64'(oreg_valid), 64'(1));
        check("oreg_c4_data",  64'(oreg_data),  64'h0C);
        apply(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        check("oreg_c5_valid", 64'(oreg_valid), 64'(0));
        check("oreg_c5_data",  64'(oreg_data),  64'h0C);

        // Randomized traffic concentrated on a few addresses to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            wa = 4'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) wa = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = 4'($urandom_range(0, 15));
            apply(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ra);
        end
        idle_bus();

        // 9-bit lanes, 36-bit words.
        b9_step(1'b0, 4'd0, 36'h0, 4'h0, 1'b1, 4'd15);
        check("b9_cleared_data",  64'(b_data),  64'h0);
        check("b9_cleared_valid", 64'(b_valid), 64'(1));
        b9_step(1'b1, 4'd0, 36'h123456789, 4'hF, 1'b0, 4'd0);
        b9_step(1'b1, 4'd15, 36'hFFFFFFFFF, 4'h8, 1'b0, 4'd0);
        check("b9_write_valid", 64'(b_valid), 64'(0));
        b9_step(1'b0, 4'd0, 36'h0, 4'h0, 1'b1, 4'd15);
        check("b9_top_lane", 64'(b_data), 64'hFF8000000);
        b9_step(1'b0, 4'd0, 36'h0, 4'h0, 1'b1, 4'd0);
        check("b9_addr0_unaffected", 64'(b_data), 64'h123456789);
        b9_step(1'b1, 4'd15, 36'hFFFFFFFFF, 4'h1, 1'b1, 4'd15);
        check("b9_collision_merge", 64'(b_data),  64'hFF80001FF);
        check("b9_collision_valid", 64'(b_valid), 64'(1));
        b9_step(1'b0, 4'd0, 36'h0, 4'h0, 1'b0, 4'd0);
        check("b9_idle_valid", 64'(b_valid), 64'(0));
        check("b9_idle_hold",  64'(b_data),  64'hFF80001FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
